// File: rtl/seq_gen.sv
// Bit-serial pattern transmitter: loads a pattern and length, then shifts it out MSB-first.
// Optional SEQ_GEN_LOOP_EN adds a `loop` input that replays the captured frame.
module seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sreg, sreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               out_n, valid_n, done_n;

  logic [CNT_W-1:0]   len_eff_c;
  logic [WIDTH-1:0]   aligned_c;
  logic               start_c;
  logic [WIDTH-1:0]   start_pat_c;
  logic [CNT_W-1:0]   start_len_c;

`ifdef SEQ_GEN_LOOP_EN
  logic               loop_q, loop_n;
  logic [WIDTH-1:0]   cap_pat, cap_pat_n;
  logic [CNT_W-1:0]   cap_len, cap_len_n;
`endif

  // Clamp the requested length and left-align the pattern so its first bit sits at the MSB.
  always_comb begin
    if (len > LEN_W'(WIDTH)) len_eff_c = CNT_W'(WIDTH);
    else                     len_eff_c = CNT_W'(len);
    aligned_c = pattern << (CNT_W'(WIDTH) - len_eff_c);
  end

  assign busy       = (state != S_IDLE);
  assign load_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_LOOP_EN
      loop_q    <= 1'b0;
      cap_pat   <= '0;
      cap_len   <= '0;
`endif
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      gap_cnt   <= gap_n;
      out       <= out_n;
      out_valid <= valid_n;
      done      <= done_n;
`ifdef SEQ_GEN_LOOP_EN
      loop_q    <= loop_n;
      cap_pat   <= cap_pat_n;
      cap_len   <= cap_len_n;
`endif
    end
  end

  // cnt holds the number of bits still to send after the one currently on `out`.
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    gap_n       = gap_cnt;
    out_n       = 1'b0;
    valid_n     = 1'b0;
    done_n      = 1'b0;
    start_c     = 1'b0;
    start_pat_c = aligned_c;
    start_len_c = len_eff_c;
`ifdef SEQ_GEN_LOOP_EN
    loop_n      = loop_q;
    cap_pat_n   = cap_pat;
    cap_len_n   = cap_len;
`endif

    case (state)
      S_IDLE: begin
        if (load_valid) begin
          if (len_eff_c == '0) begin
            done_n = 1'b1;
          end else begin
            start_c = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
            cap_pat_n = aligned_c;
            cap_len_n = len_eff_c;
`endif
          end
        end
      end
      S_SHIFT: begin
        if (cnt != '0) begin
          out_n   = sreg[WIDTH-1];
          sreg_n  = sreg << 1;
          cnt_n   = cnt - CNT_W'(1);
          valid_n = 1'b1;
        end else begin
          done_n = 1'b1;
          if (GAP > 0) begin
            state_n = S_GAP;
            gap_n   = GAP_W'(GAP - 1);
`ifdef SEQ_GEN_LOOP_EN
            loop_n  = loop;
`endif
          end else begin
            state_n = S_IDLE;
`ifdef SEQ_GEN_LOOP_EN
            if (loop) begin
              start_c     = 1'b1;
              start_pat_c = cap_pat;
              start_len_c = cap_len;
            end
`endif
          end
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_n = gap_cnt - GAP_W'(1);
        end else begin
          state_n = S_IDLE;
`ifdef SEQ_GEN_LOOP_EN
          if (loop_q) begin
            start_c     = 1'b1;
            start_pat_c = cap_pat;
            start_len_c = cap_len;
          end
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Frame start: the first bit is registered on the same edge that accepts or reloads.
    if (start_c) begin
      state_n = S_SHIFT;
      out_n   = start_pat_c[WIDTH-1];
      sreg_n  = start_pat_c << 1;
      cnt_n   = start_len_c - CNT_W'(1);
      valid_n = 1'b1;
    end
  end

endmodule
